// File: rtl/seq_stream_ctrl.sv
// Frame controller for the serial "1011" detector: takes a frame of words over
// valid/ready, shifts them out MSB-first without gaps, and counts detector hits.
module seq_stream_ctrl #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [LEN_W-1:0]  cfg_len_i,
    input  logic              data_valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              data_ready_o,
    output logic              det_in_o,
    output logic              det_clr_o,
    input  logic              det_hit_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  hit_count_o
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SHIFT, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] nxt_q, nxt_d;
    logic              nxt_valid_q, nxt_valid_d;
    logic [DATA_W-1:0] cur_q, cur_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [LEN_W-1:0]  acc_q, acc_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hit_qual_q, hit_qual_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ready;
    logic              xfer;
    logic              last_bit;

    always_comb begin
        state_d     = state_q;
        nxt_d       = nxt_q;
        nxt_valid_d = nxt_valid_q;
        cur_d       = cur_q;
        bit_d       = bit_q;
        rem_d       = rem_q;
        acc_d       = acc_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        done_d      = 1'b0;
        hit_qual_d  = 1'b0;

        ready    = ((state_q == S_CLEAR) || (state_q == S_SHIFT)) && !nxt_valid_q && (acc_q < len_q);
        xfer     = data_valid_i && ready && !abort_i;
        last_bit = (bit_q == BIT_W'(DATA_W - 1));

        if (hit_qual_q && det_hit_i && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    len_d       = cfg_len_i;
                    cnt_d       = '0;
                    err_d       = 1'b0;
                    acc_d       = '0;
                    nxt_valid_d = 1'b0;
                    if (cfg_len_i == '0) done_d  = 1'b1;
                    else                 state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (abort_i) begin
                    state_d     = S_IDLE;
                    nxt_valid_d = 1'b0;
                end else if (nxt_valid_q) begin
                    cur_d       = nxt_q;
                    nxt_valid_d = 1'b0;
                    rem_d       = len_q - LEN_W'(1);
                    bit_d       = '0;
                    state_d     = S_SHIFT;
                end
            end
            S_SHIFT: begin
                hit_qual_d = 1'b1;
                cur_d      = cur_q << 1;
                bit_d      = bit_q + BIT_W'(1);
                // Hits surfacing after an abort or underrun belong to a dead frame.
                if (abort_i) begin
                    state_d     = S_IDLE;
                    nxt_valid_d = 1'b0;
                    hit_qual_d  = 1'b0;
                end else if (last_bit) begin
                    bit_d = '0;
                    if (rem_q != '0) begin
                        if (nxt_valid_q) begin
                            cur_d       = nxt_q;
                            nxt_valid_d = 1'b0;
                            rem_d       = rem_q - LEN_W'(1);
                        end else begin
                            state_d    = S_IDLE;
                            err_d      = 1'b1;
                            hit_qual_d = 1'b0;
                        end
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_IDLE;
                if (abort_i) nxt_valid_d = 1'b0;
                else         done_d      = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Placed after the load so a refill in the same cycle wins over the clear.
        if (xfer) begin
            nxt_d       = data_i;
            nxt_valid_d = 1'b1;
            acc_d       = acc_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            nxt_q       <= '0;
            nxt_valid_q <= 1'b0;
            cur_q       <= '0;
            bit_q       <= '0;
            rem_q       <= '0;
            acc_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            hit_qual_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            nxt_q       <= nxt_d;
            nxt_valid_q <= nxt_valid_d;
            cur_q       <= cur_d;
            bit_q       <= bit_d;
            rem_q       <= rem_d;
            acc_q       <= acc_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            hit_qual_q  <= hit_qual_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign data_ready_o = ready;
    assign det_in_o     = (state_q == S_SHIFT) && cur_q[DATA_W-1];
    assign det_clr_o    = (state_q == S_IDLE) || (state_q == S_CLEAR);
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign hit_count_o  = cnt_q;

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Directed bench for seq_stream_ctrl with a behavioural overlapping "1011"
// Moore detector on each DUT; a second DUT with CNT_W=2 exercises saturation.
module tb_seq_stream_ctrl;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        start_i, abort_i;
    logic [7:0]  cfg_len_i;
    logic        data_valid_i;
    logic [7:0]  data_i;
    logic        data_ready_o, det_in_o, det_clr_o, busy_o, done_o, err_o;
    logic [15:0] hit_count_o;
    logic        det_hit;
    logic        rdy2, din2, clr2, busy2, done2, err2;
    logic [1:0]  cnt2;
    logic        det_hit2;

    always #5 clk = ~clk;

    seq_stream_ctrl #(.DATA_W(8), .LEN_W(8), .CNT_W(16)) dut (
        .clk_i(clk), .reset_ni(reset_ni), .start_i(start_i), .abort_i(abort_i),
        .cfg_len_i(cfg_len_i), .data_valid_i(data_valid_i), .data_i(data_i),
        .data_ready_o(data_ready_o), .det_in_o(det_in_o), .det_clr_o(det_clr_o),
        .det_hit_i(det_hit), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .hit_count_o(hit_count_o)
    );

    seq_stream_ctrl #(.DATA_W(8), .LEN_W(8), .CNT_W(2)) dut2 (
        .clk_i(clk), .reset_ni(reset_ni), .start_i(start_i), .abort_i(abort_i),
        .cfg_len_i(cfg_len_i), .data_valid_i(data_valid_i), .data_i(data_i),
        .data_ready_o(rdy2), .det_in_o(din2), .det_clr_o(clr2),
        .det_hit_i(det_hit2), .busy_o(busy2), .done_o(done2), .err_o(err2),
        .hit_count_o(cnt2)
    );

    // Overlapping Moore detector: 0 idle, 1 "1", 2 "10", 3 "101", 4 "1011" (hit).
    function automatic logic [2:0] det_next(input logic [2:0] s, input logic b);
        case (s)
            3'd0:    det_next = b ? 3'd1 : 3'd0;
            3'd1:    det_next = b ? 3'd1 : 3'd2;
            3'd2:    det_next = b ? 3'd3 : 3'd0;
            3'd3:    det_next = b ? 3'd4 : 3'd2;
            default: det_next = b ? 3'd1 : 3'd2;
        endcase
    endfunction

    logic [2:0] dst, dst2;
    always_ff @(posedge clk) begin
        dst  <= det_clr_o ? 3'd0 : det_next(dst, det_in_o);
        dst2 <= clr2      ? 3'd0 : det_next(dst2, din2);
    end
    assign det_hit  = (dst == 3'd4);
    assign det_hit2 = (dst2 == 3'd4);

    int npass = 0;
    int ntotal = 0;
    int ndone = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Word source for the multi-word sequences.
    logic [7:0] words [4];
    int         nwords;
    int         widx;
    logic       src_en = 1'b0;

    task automatic step();
        logic x;
        x = data_valid_i && data_ready_o && !abort_i;
        @(posedge clk);
        #1;
        if (src_en) begin
            if (x) widx++;
            data_valid_i = (widx < nwords);
            data_i       = (widx < nwords) ? words[widx] : 8'h00;
        end
        if (done_o) ndone++;
    endtask

    task automatic start_frame(input logic [7:0] len);
        start_i   = 1'b1;
        cfg_len_i = len;
        step();
        start_i   = 1'b0;
    endtask

    typedef struct {
        logic       start;
        logic       valid;
        logic [7:0] data;
        logic       busy;
        logic       clr;
        logic       rdy;
        logic       din;
        logic       done;
        logic [15:0] cnt;
    } vec_t;

    vec_t vt [13];

    initial begin
        logic [15:0] stream;
        int d0;

        // c0..c12 of a LEN=1 frame carrying 0xB0; hit appears at c7, counted from c8.
        for (int k = 0; k < 13; k++) begin
            vt[k].start = (k == 0);
            vt[k].valid = 1'b1;
            vt[k].data  = 8'hB0;
            vt[k].busy  = (k >= 1 && k <= 11);
            vt[k].clr   = (k <= 2 || k == 12);
            vt[k].rdy   = (k == 1);
            vt[k].din   = 1'b0;
            vt[k].done  = (k == 12);
            vt[k].cnt   = (k >= 8) ? 16'd1 : 16'd0;
        end
        vt[3].din = 1'b1;
        vt[5].din = 1'b1;
        vt[6].din = 1'b1;

        reset_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; cfg_len_i = 8'd1;
        data_valid_i = 1'b0; data_i = 8'h00;

        for (int i = 0; i < 3; i++) begin
            start_i = i[0];
            @(posedge clk);
            #1;
            chk($sformatf("rst%0d_clr", i),  det_clr_o, 1'b1);
            chk($sformatf("rst%0d_busy", i), busy_o, 1'b0);
        end
        chk("rst_rdy",  data_ready_o, 1'b0);
        chk("rst_din",  det_in_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_err",  err_o, 1'b0);
        chk("rst_cnt",  hit_count_o, 16'd0);
        start_i = 1'b0;
        reset_ni = 1'b1;
        step();
        step();

        // LEN=1, word 0xB0, cycle-exact table.
        cfg_len_i = 8'd1;
        for (int k = 0; k < 13; k++) begin
            start_i      = vt[k].start;
            data_valid_i = vt[k].valid;
            data_i       = vt[k].data;
            chk($sformatf("l1_c%0d_busy", k), busy_o, vt[k].busy);
            chk($sformatf("l1_c%0d_clr", k),  det_clr_o, vt[k].clr);
            chk($sformatf("l1_c%0d_rdy", k),  data_ready_o, vt[k].rdy);
            chk($sformatf("l1_c%0d_din", k),  det_in_o, vt[k].din);
            chk($sformatf("l1_c%0d_done", k), done_o, vt[k].done);
            chk($sformatf("l1_c%0d_cnt", k),  hit_count_o, 32'(vt[k].cnt));
            step();
        end
        data_valid_i = 1'b0;
        chk("l1_done_gone", done_o, 1'b0);
        step();

        // LEN=2, 0xB6 then 0xBB: gapless 16 bits, 4 overlapping hits, one done.
        words[0] = 8'hB6; words[1] = 8'hBB; nwords = 2; widx = 0;
        src_en = 1'b1; data_valid_i = 1'b1; data_i = words[0];
        d0 = ndone;
        stream = 16'hB6BB;
        start_frame(8'd2);
        step(); step();
        for (int b = 0; b < 16; b++) begin
            chk($sformatf("l2_bit%0d", b), det_in_o, stream[15-b]);
            chk($sformatf("l2_clr%0d", b), det_clr_o, 1'b0);
            step();
        end
        chk("l2_drain_busy", busy_o, 1'b1);
        chk("l2_drain_din",  det_in_o, 1'b0);
        step();
        chk("l2_done",  done_o, 1'b1);
        chk("l2_cnt",   hit_count_o, 16'd4);
        chk("l2_sat",   cnt2, 2'd3);
        step(); step();
        chk("l2_ndone", ndone - d0, 1);
        chk("l2_hold",  hit_count_o, 16'd4);

        // LEN=3 with only one word 0x0B: underrun at end of word 1, final-bit hit dropped.
        words[0] = 8'h0B; nwords = 1; widx = 0;
        data_valid_i = 1'b1; data_i = words[0];
        d0 = ndone;
        start_frame(8'd3);
        for (int c = 1; c < 11; c++) step();
        chk("ur_err",  err_o, 1'b1);
        chk("ur_busy", busy_o, 1'b0);
        chk("ur_clr",  det_clr_o, 1'b1);
        step();
        chk("ur_cnt",   hit_count_o, 16'd0);
        chk("ur_ndone", ndone - d0, 0);
        chk("ur_err_sticky", err_o, 1'b1);
        src_en = 1'b0; data_valid_i = 1'b0;

        // LEN=0 start: clears err, done next cycle, no ready.
        start_i = 1'b1; cfg_len_i = 8'd0;
        chk("z_rdy0", data_ready_o, 1'b0);
        step();
        start_i = 1'b0;
        chk("z_done", done_o, 1'b1);
        chk("z_err",  err_o, 1'b0);
        chk("z_cnt",  hit_count_o, 16'd0);
        chk("z_busy", busy_o, 1'b0);
        chk("z_rdy1", data_ready_o, 1'b0);
        step();
        chk("z_done_gone", done_o, 1'b0);
        chk("z_rdy2", data_ready_o, 1'b0);

        // Abort on the 4th bit of 0xBB, with start_i in the same cycle.
        words[0] = 8'hBB; nwords = 1; widx = 0;
        src_en = 1'b1; data_valid_i = 1'b1; data_i = words[0];
        d0 = ndone;
        start_frame(8'd1);
        for (int c = 1; c < 6; c++) step();
        chk("ab_pre_din", det_in_o, 1'b1);
        abort_i = 1'b1; start_i = 1'b1; cfg_len_i = 8'd1;
        step();
        abort_i = 1'b0; start_i = 1'b0;
        chk("ab_busy", busy_o, 1'b0);
        chk("ab_clr",  det_clr_o, 1'b1);
        chk("ab_done", done_o, 1'b0);
        chk("ab_err",  err_o, 1'b0);
        step();
        chk("ab_idle",  busy_o, 1'b0);
        chk("ab_cnt",   hit_count_o, 16'd0);
        chk("ab_ndone", ndone - d0, 0);
        src_en = 1'b0; data_valid_i = 1'b0;
        step();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
